// File: rtl/mul_accum.sv
// Per-lane dot-product accumulator behind the radix-8 multiplier array, with valid/ready output.
// Optional feature: define MUL_ACCUM_SAT_EN to saturate lanes on overflow instead of wrapping.
module mul_accum #(
  parameter int unsigned B_NUM = 1,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned LEN_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        iStart,
  input  logic [LEN_W-1:0]            iLen,
  input  logic                        iValid,
  input  logic [B_NUM-1:0][15:0]      iRslt,
  input  logic                        iReady,
  output logic                        oValid,
  output logic [B_NUM-1:0][ACC_W-1:0] oAcc,
  output logic [B_NUM-1:0]            oOvf,
  output logic                        oBusy,
  output logic                        oErr
);

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e                      state_q, state_d;
  logic [LEN_W-1:0]            cnt_q, cnt_d, len_q, len_d, cnt_inc;
  logic [B_NUM-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [B_NUM-1:0]            ovf_q, ovf_d;
  logic                        err_q, err_d;
  logic                        valid_q, busy_q;
  logic [B_NUM-1:0][ACC_W:0]   sum;

  // One extra bit per lane captures the carry out of the accumulator.
  always_comb begin
    for (int i = 0; i < int'(B_NUM); i++) begin
      sum[i] = {1'b0, acc_q[i]} + {{(ACC_W - 15){1'b0}}, iRslt[i]};
    end
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (iStart) begin
          if (iLen != '0) begin
            state_d = StAccum;
            cnt_d   = '0;
            len_d   = iLen;
            acc_d   = '0;
            ovf_d   = '0;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        // A product arriving with the accepted start is still a protocol error.
        if (iValid) err_d = 1'b1;
      end
      StAccum: begin
        if (iValid) begin
          for (int i = 0; i < int'(B_NUM); i++) begin
`ifdef MUL_ACCUM_SAT_EN
            acc_d[i] = sum[i][ACC_W] ? '1 : sum[i][ACC_W-1:0];
`else
            acc_d[i] = sum[i][ACC_W-1:0];
`endif
            ovf_d[i] = ovf_q[i] | sum[i][ACC_W];
          end
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = StHold;
        end
      end
      StHold: begin
        if (iValid) err_d = 1'b1;
        if (iReady) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      valid_q <= (state_d == StHold);
      busy_q  <= (state_d != StIdle);
    end
  end

  assign oValid = valid_q;
  assign oAcc   = acc_q;
  assign oOvf   = ovf_q;
  assign oBusy  = busy_q;
  assign oErr   = err_q;

endmodule

// File: tb/tb_mul_accum.sv
// Randomised self-checking bench for mul_accum: 24-bit and 16-bit lane instances share stimulus.
// Expected sums come from plain running totals; honours MUL_ACCUM_SAT_EN when defined.
module tb_mul_accum;

  logic                  clk, rst_n;
  logic                  start, valid_in, ready;
  logic [7:0]            len;
  logic [1:0][15:0]      rslt;
  logic                  valid24, busy24, err24, valid16, busy16, err16;
  logic [1:0][23:0]      acc24;
  logic [1:0][15:0]      acc16;
  logic [1:0]            ovf24, ovf16;

  int                    n_vec, n_bad;
  longint                tot[2];
  bit                    exp_err;
  int                    basic_tab[3] = '{10, 20, 30};

  mul_accum #(.B_NUM(2), .ACC_W(24), .LEN_W(8)) u_dut24 (
    .clk(clk), .rst(rst_n), .iStart(start), .iLen(len), .iValid(valid_in), .iRslt(rslt),
    .iReady(ready), .oValid(valid24), .oAcc(acc24), .oOvf(ovf24), .oBusy(busy24), .oErr(err24)
  );

  mul_accum #(.B_NUM(2), .ACC_W(16), .LEN_W(8)) u_dut16 (
    .clk(clk), .rst(rst_n), .iStart(start), .iLen(len), .iValid(valid_in), .iRslt(rslt),
    .iReady(ready), .oValid(valid16), .oAcc(acc16), .oOvf(ovf16), .oBusy(busy16), .oErr(err16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint exp_acc(input longint total, input int w);
    longint lim = longint'(1) << w;
`ifdef MUL_ACCUM_SAT_EN
    return (total >= lim) ? lim - 1 : total;
`else
    return total % lim;
`endif
  endfunction

  function automatic bit exp_ovf(input longint total, input int w);
    return total >= (longint'(1) << w);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input bit ev, input bit eb, input bit ca);
    chk({tag, ".valid24"}, 64'(valid24), 64'(ev));
    chk({tag, ".valid16"}, 64'(valid16), 64'(ev));
    chk({tag, ".busy24"}, 64'(busy24), 64'(eb));
    chk({tag, ".busy16"}, 64'(busy16), 64'(eb));
    chk({tag, ".err24"}, 64'(err24), 64'(exp_err));
    chk({tag, ".err16"}, 64'(err16), 64'(exp_err));
    if (ca) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("%s.acc24[%0d]", tag, i), 64'(acc24[i]), 64'(exp_acc(tot[i], 24)));
        chk($sformatf("%s.ovf24[%0d]", tag, i), 64'(ovf24[i]), 64'(exp_ovf(tot[i], 24)));
        chk($sformatf("%s.acc16[%0d]", tag, i), 64'(acc16[i]), 64'(exp_acc(tot[i], 16)));
        chk($sformatf("%s.ovf16[%0d]", tag, i), 64'(ovf16[i]), 64'(exp_ovf(tot[i], 16)));
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_products(input int pmode, input int k);
    int p0, p1;
    case (pmode)
      1:       begin p0 = basic_tab[k]; p1 = 65025; end
      2:       begin p0 = 65025;        p1 = 65025; end
      default: begin
        p0 = $urandom_range(0, 255) * $urandom_range(0, 255);
        p1 = $urandom_range(0, 255) * $urandom_range(0, 255);
      end
    endcase
    rslt[0] = 16'(p0);
    rslt[1] = 16'(p1);
    tot[0] += longint'(p0);
    tot[1] += longint'(p1);
  endtask

  // hold_wait < 0: iReady is already high when oValid rises (single-cycle HOLD).
  task automatic run_txn(input int n, input int gap_pct, input int hold_wait,
                         input bit start_valid, input bit hold_err, input int pmode);
    int w;
    start    = 1'b1;
    len      = 8'(n);
    valid_in = start_valid;
    rslt     = 32'($urandom);
    ready    = 1'b0;
    step();
    tot[0]  = 0;
    tot[1]  = 0;
    exp_err = start_valid;
    check_all("start", 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < 8 && $urandom_range(0, 99) < gap_pct; g++) begin
        valid_in = 1'b0;
        start    = 1'($urandom);
        len      = 8'($urandom);
        ready    = (hold_wait < 0) ? 1'b1 : 1'($urandom);
        step();
        check_all("gap", 1'b0, 1'b1, 1'b1);
      end
      valid_in = 1'b1;
      start    = 1'($urandom);
      len      = 8'($urandom);
      ready    = (hold_wait < 0) ? 1'b1 : 1'($urandom);
      set_products(pmode, k);
      step();
      check_all("add", (k == n - 1), 1'b1, 1'b1);
    end
    w = (hold_wait < 0) ? 0 : hold_wait;
    for (int j = 0; j < w; j++) begin
      ready    = 1'b0;
      start    = 1'($urandom);
      valid_in = hold_err && (j == 0);
      rslt     = 32'($urandom);
      if (valid_in) exp_err = 1'b1;
      step();
      check_all("hold", 1'b1, 1'b1, 1'b1);
    end
    ready    = 1'b1;
    start    = 1'($urandom);
    valid_in = hold_err && (w == 0);
    if (valid_in) exp_err = 1'b1;
    step();
    check_all("xfer", 1'b0, 1'b0, 1'b0);
    start    = 1'b0;
    valid_in = 1'b0;
    ready    = 1'b0;
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    exp_err  = 1'b0;
    tot[0]   = 0;
    tot[1]   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    len      = '0;
    valid_in = 1'b0;
    rslt     = '0;
    ready    = 1'b0;
    #12;
    check_all("reset", 1'b0, 1'b0, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    step();

    run_txn(3, 0, -1, 1'b0, 1'b0, 1);   // lane0 10+20+30, lane1 3x65025
    run_txn(2, 60, 5, 1'b0, 1'b0, 0);   // gaps plus backpressure
    run_txn(2, 0, 2, 1'b0, 1'b0, 2);    // 16-bit lanes overflow

    start = 1'b1;
    len   = '0;
    step();
    start   = 1'b0;
    exp_err = 1'b1;
    check_all("len0", 1'b0, 1'b0, 1'b0);
    exp_err  = 1'b0;
    run_txn(1, 0, 0, 1'b0, 1'b0, 0);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    exp_err  = 1'b1;
    check_all("idle_valid", 1'b0, 1'b0, 1'b0);

    run_txn(3, 20, 3, 1'b0, 1'b1, 0);   // iValid while holding
    run_txn(2, 0, 1, 1'b0, 1'b0, 0);    // good start clears the error
    run_txn(2, 0, 0, 1'b1, 1'b0, 0);    // product alongside the start

    // Asynchronous reset two products into a length-5 dot product.
    start = 1'b1;
    len   = 8'd5;
    step();
    start   = 1'b0;
    tot[0]  = 0;
    tot[1]  = 0;
    exp_err = 1'b0;
    for (int k = 0; k < 2; k++) begin
      valid_in = 1'b1;
      set_products(0, k);
      step();
      check_all("rst_add", 1'b0, 1'b1, 1'b1);
    end
    valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tot[0] = 0;
    tot[1] = 0;
    check_all("rst_async", 1'b0, 1'b0, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    step();
    run_txn(4, 10, 1, 1'b0, 1'b0, 0);

    run_txn(255, 0, 1, 1'b0, 1'b0, 2); // maximum length

    for (int t = 0; t < 40; t++) begin
      run_txn($urandom_range(1, 12), $urandom_range(0, 40), int'($urandom_range(0, 4)) - 1,
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mul_accum.md
# mul_accum

Downstream result accumulator for the `Unsigned8mul` radix-8 multiplier array. It consumes the per-lane 16-bit unsigned products `oRslt[B_NUM-1:0]` and sums a programmed number of valid products per lane into a wide accumulator. It then presents the finished dot-product vector to the next stage over a valid/ready handshake. The multiplier's pipeline delay is absorbed upstream: `iValid` is already aligned with `iRslt`.

## Interface
- `B_NUM`, 1, lane count; must match the feeding `Unsigned8mul`.
- `ACC_W`, 24, accumulator width per lane; must be ≥ 16.
- `LEN_W`, 8, width of the product-count field.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `iStart` in 1: begin a new dot product; accepted only in IDLE.
- `iLen` in LEN_W: number of products to accumulate; sampled with an accepted `iStart`.
- `iValid` in 1: `iRslt` holds a product for every lane this cycle.
- `iRslt` in [B_NUM-1:0][15:0]: lane products.
- `iReady` in 1: downstream can take the result.
- `oValid` out 1: `oAcc` holds a finished dot product.
- `oAcc` out [B_NUM-1:0][ACC_W-1:0]: per-lane sums.
- `oOvf` out [B_NUM-1:0]: per-lane overflow flag, sticky over one dot product.
- `oBusy` out 1: high in ACCUM or HOLD.
- `oErr` out 1: sticky protocol error; cleared by the next accepted `iStart`.

## Operation
- **IDLE**
  - `iStart=1` and `iLen≠0`: clear `oAcc`, `oOvf`, `oErr` and the counter; latch `iLen`; go to ACCUM.
  - `iStart=1` and `iLen=0`: set `oErr`; stay in IDLE.
  - `iValid=1` in IDLE: set `oErr`; the product is discarded. This includes the cycle in which `iStart` is accepted.
- **ACCUM**
  - Each cycle with `iValid=1`: `oAcc[i] += iRslt[i]` for every lane, and the counter increments.
  - When the counter reaches the latched length, on that same add cycle: go to HOLD.
  - `iStart` is ignored.
- **HOLD**
  - `oValid=1`; `oAcc` and `oOvf` are frozen.
  - A transfer occurs when `oValid && iReady`; the next state is IDLE.
  - `iValid=1` in HOLD: set `oErr`; the product is discarded.
  - `iStart` is ignored, including in the transfer cycle.
- **Arithmetic**
  - Unsigned add: the 16-bit product is zero-extended to `ACC_W`.
  - Overflow means a carry out of bit `ACC_W-1`.
  - Overflow behaviour is set per Configuration.
- **Counter**: `LEN_W` bits; the terminal compare is `count+1 == len`. With `LEN_W=8` the maximum length is 255, and no wrap occurs.
- **Reset mid-operation**: asynchronous return to IDLE. An in-flight dot product is lost.
- **Reset values**: `oValid=0`, `oAcc=0`, `oOvf=0`, `oBusy=0`, `oErr=0`.

## Timing
- All outputs are registered.
- Last product accepted at edge t → `oValid=1` and the final `oAcc` are visible after edge t (cycle t+1).
- `oValid` is held high until `iReady`; `oValid` and `oAcc` must not change while `oValid && !iReady`.
- `iReady` may be high before `oValid`, giving single-cycle HOLD.
- Minimum period between `iStart` accepts is `len` + 2 cycles: start cycle, `len` add cycles, one HOLD cycle.
- `oBusy` rises the cycle after `iStart` is accepted and falls the cycle after the transfer.
- Throughput in ACCUM is one product vector per cycle. Gaps in `iValid` stall the count without penalty.

## Configuration
- `MUL_ACCUM_SAT_EN` defined:
  - On overflow, the lane saturates to 2^ACC_W−1 and stays there for the rest of the dot product.
  - `oOvf[i]` is set at that time.
- Not defined:
  - The lane wraps modulo 2^ACC_W.
  - `oOvf[i]` still records the sticky carry-out.
  - Saturation logic is absent.

## Test plan
- **Basic sum**: `ACC_W=24`, `B_NUM=2`, `iLen=3`; products lane0 10,20,30 and lane1 255·255 ×3, back-to-back, `iReady=1` → one cycle after the 3rd valid, `oValid=1`, `oAcc[0]=60`, `oAcc[1]=195075`, `oOvf=0`; IDLE the next cycle.
- **Backpressure and gaps**: `iLen=2`; valids at cycles 1 and 4, `iReady=0` for 5 cycles, then 1 → `oValid` high continuously and `oAcc` stable; single transfer; `oBusy` falls one cycle after the transfer.
- **Overflow**: `ACC_W=16`, `iLen=2`, products 65025, 65025.
  - Without the macro: `oAcc=64514`, `oOvf=1`.
  - With `MUL_ACCUM_SAT_EN`: `oAcc=65535`, `oOvf=1`.
- **Protocol errors**:
  - `iStart` with `iLen=0` → `oErr=1`, stays in IDLE.
  - `iValid` in HOLD → `oErr=1`; `oAcc` unchanged.
  - A following good `iStart` clears `oErr`.
- **Reset mid-ACCUM**: `iLen=5`; after 2 products assert `rst=0` asynchronously between edges → all outputs 0 immediately; after release, a new `iStart` works normally.
- **Maximum length**: `LEN_W=8`, `iLen=255`, all products 65025, `ACC_W=24` → `oAcc=16581375`, `oOvf=0`, `oValid` exactly one cycle after the 255th valid.
